// File: rtl/riscv_alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// Two-stage pipeline: issue stage X drives the ALU, stage R holds the response.
module riscv_alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_a,
    input  logic [NREQ*32-1:0]  req_b,
    input  logic [NREQ*5-1:0]   req_op,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [31:0]         rsp_result,
    output logic                rsp_flag,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [4:0]          alu_op,
    input  logic [31:0]         alu_result,
    input  logic                alu_flag,
    output logic                busy
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  ptr_q, ptr_d;

    logic            x_valid_q, x_valid_d;
    logic [31:0]     x_a_q, x_a_d;
    logic [31:0]     x_b_q, x_b_d;
    logic [4:0]      x_op_q, x_op_d;
    logic [IDW-1:0]  x_id_q, x_id_d;

    logic            r_valid_q, r_valid_d;
    logic [31:0]     r_result_q, r_result_d;
    logic            r_flag_q, r_flag_d;
    logic [IDW-1:0]  r_id_q, r_id_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            gfound;
    logic            r_free;
    logic            x_adv;
    logic            x_free;
    logic            accept;

    assign r_free = !r_valid_q | rsp_ready[r_id_q];
    assign x_adv  = x_valid_q & r_free;
    assign x_free = !x_valid_q | x_adv;

    // Circular first-valid search starting at the round-robin pointer
    always_comb begin
        grant  = '0;
        gidx   = '0;
        gfound = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gfound && req_valid[idx]) begin
                gfound    = 1'b1;
                grant[idx] = 1'b1;
                gidx      = IDW'(idx);
            end
        end
    end

    assign req_ready = grant & {NREQ{x_free & rst_n}};
    assign accept    = |req_ready;

    // Issue stage and pointer next state: load on accept, empty on advance
    always_comb begin
        ptr_d     = ptr_q;
        x_valid_d = x_valid_q;
        x_a_d     = x_a_q;
        x_b_d     = x_b_q;
        x_op_d    = x_op_q;
        x_id_d    = x_id_q;
        if (accept) begin
            x_valid_d = 1'b1;
            x_a_d     = req_a[int'(gidx)*32 +: 32];
            x_b_d     = req_b[int'(gidx)*32 +: 32];
            x_op_d    = req_op[int'(gidx)*5 +: 5];
            x_id_d    = gidx;
            if (int'(gidx) == NREQ - 1) ptr_d = '0;
            else                        ptr_d = IDW'(int'(gidx) + 1);
        end else if (x_adv) begin
            x_valid_d = 1'b0;
            x_a_d     = '0;
            x_b_d     = '0;
            x_op_d    = '0;
            x_id_d    = '0;
        end
    end

    // Response stage next state: capture ALU on advance, retire on handshake
    always_comb begin
        r_valid_d  = r_valid_q;
        r_result_d = r_result_q;
        r_flag_d   = r_flag_q;
        r_id_d     = r_id_q;
        if (x_adv) begin
            r_valid_d  = 1'b1;
            r_result_d = alu_result;
            r_flag_d   = alu_flag;
            r_id_d     = x_id_q;
        end else if (r_valid_q && rsp_ready[r_id_q]) begin
            r_valid_d = 1'b0;
        end
    end

    // Pipeline state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            x_valid_q  <= 1'b0;
            x_a_q      <= '0;
            x_b_q      <= '0;
            x_op_q     <= '0;
            x_id_q     <= '0;
            r_valid_q  <= 1'b0;
            r_result_q <= '0;
            r_flag_q   <= 1'b0;
            r_id_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            x_valid_q  <= x_valid_d;
            x_a_q      <= x_a_d;
            x_b_q      <= x_b_d;
            x_op_q     <= x_op_d;
            x_id_q     <= x_id_d;
            r_valid_q  <= r_valid_d;
            r_result_q <= r_result_d;
            r_flag_q   <= r_flag_d;
            r_id_q     <= r_id_d;
        end
    end

    // Route the response-stage valid to its owning requester
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = r_valid_q & (r_id_q == IDW'(i));
        end
    end

    assign rsp_result = r_result_q;
    assign rsp_flag   = r_flag_q;
    assign alu_a      = x_a_q;
    assign alu_b      = x_b_q;
    assign alu_op     = x_op_q;
    assign busy       = x_valid_q | r_valid_q;

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Directed bench for riscv_alu_arbiter (NREQ=2 and NREQ=3 instances).
// The ALU is a small behavioural model attached to the alu_* ports.
module tb_riscv_alu_arbiter;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_BLT  = 5'b11100;
    localparam logic [4:0] OP_BLTU = 5'b11110;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [1:0]  rv, rdy, rsv, rsr;
    logic [63:0] ra, rb;
    logic [9:0]  ro;
    logic [31:0] res, aa, ab, alr;
    logic [4:0]  aop;
    logic        fl, af, bsy;

    logic [2:0]  rv3, rdy3, rsv3, rsr3;
    logic [95:0] ra3, rb3;
    logic [14:0] ro3;
    logic [31:0] res3, aa3, ab3, alr3;
    logic [4:0]  aop3;
    logic        fl3, af3, bsy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_m(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [4:0] op);
        case (op)
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return {1'b0, a - b};
            OP_BLT:  return {($signed(a) < $signed(b)), 32'h0};
            OP_BLTU: return {(a < b), 32'h0};
            default: return 33'h0;
        endcase
    endfunction

    assign {af, alr}   = alu_m(aa, ab, aop);
    assign {af3, alr3} = alu_m(aa3, ab3, aop3);

    riscv_alu_arbiter #(.NREQ(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv), .req_ready(rdy),
        .req_a(ra), .req_b(rb), .req_op(ro),
        .rsp_valid(rsv), .rsp_ready(rsr),
        .rsp_result(res), .rsp_flag(fl),
        .alu_a(aa), .alu_b(ab), .alu_op(aop),
        .alu_result(alr), .alu_flag(af),
        .busy(bsy)
    );

    riscv_alu_arbiter #(.NREQ(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv3), .req_ready(rdy3),
        .req_a(ra3), .req_b(rb3), .req_op(ro3),
        .rsp_valid(rsv3), .rsp_ready(rsr3),
        .rsp_result(res3), .rsp_flag(fl3),
        .alu_a(aa3), .alu_b(ab3), .alu_op(aop3),
        .alu_result(alr3), .alu_flag(af3),
        .busy(bsy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slot(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] op);
        ra[i*32 +: 32] = a;
        rb[i*32 +: 32] = b;
        ro[i*5 +: 5]   = op;
    endtask

    task automatic slot3(input int i, input logic [31:0] a);
        ra3[i*32 +: 32] = a;
        rb3[i*32 +: 32] = 32'h0;
        ro3[i*5 +: 5]   = OP_ADD;
    endtask

    task automatic do_reset();
        rv    = '0;
        rsr   = '1;
        rv3   = '0;
        rsr3  = '1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k0, k1;
        int cnt3 [3];
        int g  [7] = '{1, 1, 2, 0, 1, 2, 0};
        int er [7] = '{100, 101, 200, 0, 102, 201, 1};

        rst_n = 1'b0;
        rv  = 2'b11; rsr = '1; ra = '1; rb = '1; ro = '1;
        rv3 = '0; rsr3 = '1; ra3 = '0; rb3 = '0; ro3 = '0;
        #1;
        chk("rst_ready", 32'(rdy), 32'h0);
        chk("rst_rsp_valid", 32'(rsv), 32'h0);
        chk("rst_busy", 32'(bsy), 32'h0);
        chk("rst_result", res, 32'h0);
        chk("rst_alu_a", aa, 32'h0);
        do_reset();

        // single ADD
        @(negedge clk); rv = 2'b01; slot(0, 5, 3, OP_ADD); #1;
        chk("add_ready", 32'(rdy), 32'h1);
        chk("add_busy_c0", 32'(bsy), 32'h0);
        @(negedge clk); rv = 2'b00; #1;
        chk("add_busy_c1", 32'(bsy), 32'h1);
        chk("add_rsp_c1", 32'(rsv), 32'h0);
        chk("add_alu_a", aa, 32'd5);
        chk("add_alu_b", ab, 32'd3);
        @(negedge clk); #1;
        chk("add_rsp_c2", 32'(rsv), 32'h1);
        chk("add_result", res, 32'd8);
        chk("add_flag", 32'(fl), 32'h0);
        chk("add_busy_c2", 32'(bsy), 32'h1);
        @(negedge clk); #1;
        chk("add_busy_c3", 32'(bsy), 32'h0);
        chk("add_rsp_c3", 32'(rsv), 32'h0);
        chk("add_alu_idle", 32'(aop) | aa, 32'h0);
        chk("add_hold", res, 32'd8);

        // two requesters, alternating grants, one result per cycle
        do_reset();
        k0 = 0; k1 = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rv = (c < 6) ? 2'b11 : 2'b00;
            slot(0, 32'(10 + k0), 1, OP_SUB);
            slot(1, 32'(10 + k1), 1, OP_SUB);
            #1;
            if (c < 6) chk("rr_grant", 32'(rdy), (c % 2 == 0) ? 32'h1 : 32'h2);
            if (c >= 2) begin
                chk("rr_rsp_id", 32'(rsv), ((c - 2) % 2 == 0) ? 32'h1 : 32'h2);
                chk("rr_result", res, 32'(9 + c - 2));
            end
            if (c < 6) begin
                if (c % 2 == 0) k0 += 2;
                else            k1 += 2;
            end
        end

        // branch flags
        do_reset();
        @(negedge clk); rv = 2'b01; slot(0, 32'hFFFFFFFF, 1, OP_BLT); #1;
        chk("blt_ready", 32'(rdy), 32'h1);
        @(negedge clk); slot(0, 32'hFFFFFFFF, 1, OP_BLTU); #1;
        chk("bltu_ready", 32'(rdy), 32'h1);
        chk("blt_alu_op", 32'(aop), 32'(OP_BLT));
        @(negedge clk); rv = 2'b00; #1;
        chk("blt_flag", 32'(fl), 32'h1);
        chk("blt_result", res, 32'h0);
        @(negedge clk); #1;
        chk("bltu_rsp", 32'(rsv), 32'h1);
        chk("bltu_flag", 32'(fl), 32'h0);

        // backpressure on requester 0
        do_reset();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            rv = (c <= 7) ? 2'b01 : 2'b00;
            slot(0, 32'(100 + ((c < 2) ? c : 2)), 1, OP_ADD);
            rsr[0] = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            #1;
            if (c <= 1) chk("bp_ready_fill", 32'(rdy), 32'h1);
            if (c >= 2 && c <= 6) begin
                chk("bp_ready_stall", 32'(rdy), 32'h0);
                chk("bp_rsp_stall", 32'(rsv), 32'h1);
                chk("bp_result_stable", res, 32'd101);
                chk("bp_x_stable", aa, 32'd101);
            end
            if (c == 7) chk("bp_resume", 32'(rdy), 32'h1);
            if (c >= 7 && c <= 9) begin
                chk("bp_drain_rsp", 32'(rsv), 32'h1);
                chk("bp_drain_result", res, 32'(101 + c - 7));
            end
            if (c == 10) chk("bp_empty", 32'(bsy), 32'h0);
        end

        // asynchronous reset with X and R full
        do_reset();
        @(negedge clk); rv = 2'b01; slot(0, 7, 2, OP_SUB); #1;
        chk("ar_acc0", 32'(rdy), 32'h1);
        @(negedge clk); slot(0, 9, 4, OP_SUB); #1;
        chk("ar_acc1", 32'(rdy), 32'h1);
        @(negedge clk); rsr = 2'b00; rv = 2'b11; slot(1, 1, 1, OP_SUB); #1;
        chk("ar_full_ready", 32'(rdy), 32'h0);
        chk("ar_full_rsp", 32'(rsv), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rsp_valid", 32'(rsv), 32'h0);
        chk("ar_ready", 32'(rdy), 32'h0);
        chk("ar_busy", 32'(bsy), 32'h0);
        chk("ar_alu_op", 32'(aop), 32'h0);
        chk("ar_result", res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; rsr = 2'b11; rv = 2'b11;
        slot(0, 20, 5, OP_ADD); slot(1, 30, 5, OP_ADD);
        #1;
        chk("ar_ptr0_grant", 32'(rdy), 32'h1);
        chk("ar_no_stale", 32'(rsv), 32'h0);
        @(negedge clk); rv = 2'b10; #1;
        chk("ar_grant1", 32'(rdy), 32'h2);
        chk("ar_no_stale2", 32'(rsv), 32'h0);
        @(negedge clk); rv = 2'b00; #1;
        chk("ar_rsp0", 32'(rsv), 32'h1);
        chk("ar_res0", res, 32'd25);
        @(negedge clk); #1;
        chk("ar_rsp1", 32'(rsv), 32'h2);
        chk("ar_res1", res, 32'd35);

        // NREQ=3 fairness and pointer wrap
        do_reset();
        cnt3 = '{0, 0, 0};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 2)      rv3 = 3'b010;
            else if (c < 7) rv3 = 3'b111;
            else            rv3 = 3'b000;
            for (int i = 0; i < 3; i++) slot3(i, 32'(100 * i + cnt3[i]));
            #1;
            if (c < 7) chk("fair_grant", 32'(rdy3), 32'(1 << g[c]));
            if (c >= 2) begin
                chk("fair_rsp_id", 32'(rsv3), 32'(1 << g[c - 2]));
                chk("fair_result", res3, 32'(er[c - 2]));
            end
            if (c < 7) cnt3[g[c]]++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
